// File: rtl/riscv_wb_trace_buf.sv
// Write-back trace capture: records register-file writes into a circular buffer
// drained through a valid/ready port, with end-of-program detection on a stalled fetch PC.
`timescale 1ns/1ps

module riscv_wb_trace_buf #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int DEPTH       = 64,
    parameter int PTR_W       = 6,
    parameter int TS_W        = 16,
    parameter bit WRAP_MODE   = 1'b1,
    parameter int HALT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cap_en,
    input  logic              wb_valid,
    input  logic [DWIDTH-1:0] wb_pc,
    input  logic [AWIDTH-1:0] wb_ra,
    input  logic [DWIDTH-1:0] wb_wd,
    input  logic [DWIDTH-1:0] cur_pc,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DWIDTH-1:0] rd_pc,
    output logic [AWIDTH-1:0] rd_ra,
    output logic [DWIDTH-1:0] rd_wd,
    output logic [TS_W-1:0]   rd_ts,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              overflow,
    output logic [15:0]       drop_cnt,
    output logic              halted
);

    localparam int              HC_W      = $clog2(HALT_CYCLES) + 1;
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [HC_W-1:0] HC_LAST   = HC_W'(HALT_CYCLES - 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    typedef struct packed {
        logic [DWIDTH-1:0] pc;
        logic [AWIDTH-1:0] ra;
        logic [DWIDTH-1:0] wd;
        logic [TS_W-1:0]   ts;
    } entry_t;

    state_t            state_q, state_d;
    entry_t            mem [DEPTH];
    entry_t            head_e;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [PTR_W:0]    count_q;
    logic [TS_W-1:0]   ts_q;
    logic [HC_W-1:0]   hc_q;
    logic [DWIDTH-1:0] prev_pc_q;
    logic              ovf_q, halted_q;
    logic [15:0]       drop_q;

    logic push, pop, is_full, lost, do_write, pc_same, halt_det;

    always_comb begin
        is_full  = (count_q == DEPTH_CNT);
        push     = (state_q == S_RUN) && wb_valid && (wb_ra != '0);
        pop      = (count_q != '0) && rd_ready;
        lost     = push && is_full && !pop;
        do_write = push && !(lost && !WRAP_MODE) && !clr;
        pc_same  = (cur_pc == prev_pc_q);
        halt_det = (state_q == S_RUN) && pc_same && (hc_q == HC_LAST);
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (cap_en) state_d = S_RUN;
                S_RUN: begin
                    if (halt_det)    state_d = S_HALT;
                    else if (!cap_en) state_d = S_IDLE;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: trace storage carries no reset; rd_* are masked while empty, so stale slots never leak.
    always_ff @(posedge clk) begin
        if (do_write) mem[tail_q] <= '{pc: wb_pc, ra: wb_ra, wd: wb_wd, ts: ts_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ts_q      <= '0;
            hc_q      <= '0;
            prev_pc_q <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_pc_q <= cur_pc;
            if (clr) begin
                head_q   <= '0;
                tail_q   <= '0;
                count_q  <= '0;
                ts_q     <= '0;
                hc_q     <= '0;
                ovf_q    <= 1'b0;
                drop_q   <= '0;
                halted_q <= 1'b0;
            end else begin
                if (state_q == S_RUN) ts_q <= ts_q + 1'b1;
                // The stall counter only runs while staying in RUN; any exit restarts it.
                if (state_q == S_RUN && state_d == S_RUN)
                    hc_q <= pc_same ? hc_q + 1'b1 : '0;
                else
                    hc_q <= '0;
                if (halt_det) halted_q <= 1'b1;
                if (do_write) tail_q <= tail_q + 1'b1;
                if (pop || (lost && WRAP_MODE)) head_q <= head_q + 1'b1;
                if (push && !pop && !is_full) count_q <= count_q + 1'b1;
                else if (pop && !push)        count_q <= count_q - 1'b1;
                if (lost) begin
                    ovf_q <= 1'b1;
                    if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    always_comb begin
        head_e   = mem[head_q];
        rd_valid = (count_q != '0);
        rd_pc    = rd_valid ? head_e.pc : '0;
        rd_ra    = rd_valid ? head_e.ra : '0;
        rd_wd    = rd_valid ? head_e.wd : '0;
        rd_ts    = rd_valid ? head_e.ts : '0;
    end

    assign count    = count_q;
    assign full     = is_full;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_riscv_wb_trace_buf.sv
// Bench for riscv_wb_trace_buf: a wrap-mode and a drop-mode instance share stimulus and
// are compared every cycle against a queue-based trace model.
`timescale 1ns/1ps

module tb_riscv_wb_trace_buf;

    localparam int DEPTH = 4;
    localparam int HC    = 16;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  ra;
        logic [31:0] wd;
        logic [15:0] ts;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0, cap_en = 1'b0, wb_valid = 1'b0, rd_ready = 1'b0;
    logic [31:0] wb_pc = '0, wb_wd = '0, cur_pc = 32'h1000;
    logic [4:0]  wb_ra = '0;
    bit          pc_walk = 1'b1;

    logic        o_valid [2];
    logic [31:0] o_pc    [2];
    logic [4:0]  o_ra    [2];
    logic [31:0] o_wd    [2];
    logic [15:0] o_ts    [2];
    logic [2:0]  o_count [2];
    logic        o_full  [2];
    logic        o_ovf   [2];
    logic [15:0] o_drop  [2];
    logic        o_halt  [2];
    logic [3:0]  ts_a;
    logic [15:0] ts_b;

    assign o_ts[0] = {12'd0, ts_a};
    assign o_ts[1] = ts_b;

    riscv_wb_trace_buf #(.DWIDTH(32), .AWIDTH(5), .DEPTH(DEPTH), .PTR_W(2), .TS_W(4),
                         .WRAP_MODE(1'b1), .HALT_CYCLES(HC)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cap_en(cap_en), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .wb_ra(wb_ra), .wb_wd(wb_wd), .cur_pc(cur_pc), .rd_ready(rd_ready),
        .rd_valid(o_valid[0]), .rd_pc(o_pc[0]), .rd_ra(o_ra[0]), .rd_wd(o_wd[0]), .rd_ts(ts_a),
        .count(o_count[0]), .full(o_full[0]), .overflow(o_ovf[0]), .drop_cnt(o_drop[0]),
        .halted(o_halt[0])
    );

    riscv_wb_trace_buf #(.DWIDTH(32), .AWIDTH(5), .DEPTH(DEPTH), .PTR_W(2), .TS_W(16),
                         .WRAP_MODE(1'b0), .HALT_CYCLES(HC)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cap_en(cap_en), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .wb_ra(wb_ra), .wb_wd(wb_wd), .cur_pc(cur_pc), .rd_ready(rd_ready),
        .rd_valid(o_valid[1]), .rd_pc(o_pc[1]), .rd_ra(o_ra[1]), .rd_wd(o_wd[1]), .rd_ts(ts_b),
        .count(o_count[1]), .full(o_full[1]), .overflow(o_ovf[1]), .drop_cnt(o_drop[1]),
        .halted(o_halt[1])
    );

    always #5 clk = ~clk;

    // Reference model: 0 = idle, 1 = capturing, 2 = halted
    ent_t        mq [2][$];
    int          m_st [2], m_ts [2], m_hc [2], m_drop [2];
    bit          m_ovf [2], m_halt [2];
    logic [31:0] m_prev;
    int          n_tests = 0, n_fail = 0;

    function automatic int ts_mod(input int i);
        return (i == 0) ? 16 : 65536;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_st[i] = 0; m_ts[i] = 0; m_hc[i] = 0; m_drop[i] = 0;
            m_ovf[i] = 1'b0; m_halt[i] = 1'b0;
        end
        m_prev = '0;
    endtask

    task automatic model_edge();
        ent_t e;
        int   nhc;
        bit   det, pop, push;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                mq[i].delete();
                m_st[i] = 0; m_ts[i] = 0; m_hc[i] = 0; m_drop[i] = 0;
                m_ovf[i] = 1'b0; m_halt[i] = 1'b0;
                continue;
            end
            pop  = (mq[i].size() > 0) && rd_ready;
            push = (m_st[i] == 1) && wb_valid && (wb_ra != 0);
            det  = 1'b0;
            nhc  = 0;
            if (m_st[i] == 1) begin
                nhc = (cur_pc == m_prev) ? m_hc[i] + 1 : 0;
                det = (nhc == HC - 1);
            end
            if (pop) void'(mq[i].pop_front());
            if (push) begin
                e.pc = wb_pc; e.ra = wb_ra; e.wd = wb_wd; e.ts = 16'(m_ts[i]);
                if (mq[i].size() < DEPTH) begin
                    mq[i].push_back(e);
                end else begin
                    if (i == 0) begin
                        void'(mq[i].pop_front());
                        mq[i].push_back(e);
                    end
                    m_ovf[i] = 1'b1;
                    if (m_drop[i] < 65535) m_drop[i]++;
                end
            end
            if (m_st[i] == 1) m_ts[i] = (m_ts[i] + 1) % ts_mod(i);
            case (m_st[i])
                0: if (cap_en) m_st[i] = 1;
                1: begin
                    if (det) begin
                        m_st[i] = 2;
                        m_halt[i] = 1'b1;
                    end else if (!cap_en) begin
                        m_st[i] = 0;
                    end
                end
                default: ;
            endcase
            m_hc[i] = (m_st[i] == 1) ? nhc : 0;
        end
        m_prev = cur_pc;
    endtask

    task automatic check_all();
        bit ne;
        for (int i = 0; i < 2; i++) begin
            ne = mq[i].size() > 0;
            chk($sformatf("rd_valid[%0d]", i), o_valid[i], ne);
            chk($sformatf("rd_pc[%0d]", i), o_pc[i], ne ? mq[i][0].pc : 32'd0);
            chk($sformatf("rd_ra[%0d]", i), o_ra[i], ne ? mq[i][0].ra : 5'd0);
            chk($sformatf("rd_wd[%0d]", i), o_wd[i], ne ? mq[i][0].wd : 32'd0);
            chk($sformatf("rd_ts[%0d]", i), o_ts[i], ne ? mq[i][0].ts : 16'd0);
            chk($sformatf("count[%0d]", i), o_count[i], mq[i].size());
            chk($sformatf("full[%0d]", i), o_full[i], mq[i].size() == DEPTH);
            chk($sformatf("overflow[%0d]", i), o_ovf[i], m_ovf[i]);
            chk($sformatf("drop_cnt[%0d]", i), o_drop[i], m_drop[i]);
            chk($sformatf("halted[%0d]", i), o_halt[i], m_halt[i]);
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        if (pc_walk) cur_pc = cur_pc + 32'd4;
        check_all();
    endtask

    task automatic wr(input logic [4:0] ra, input logic [31:0] wd);
        wb_valid = 1'b1; wb_ra = ra; wb_wd = wd; wb_pc = wd << 2;
        cyc();
        wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t1;
        logic [31:0] got [4];

        // Reset
        model_reset();
        #3 rst_n = 1'b0;
        #1 check_all();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Basic capture: x0 write is filtered
        cap_en = 1'b1;
        cyc();
        wr(5'd1, 32'h5);
        wr(5'd2, 32'hA);
        wr(5'd0, 32'hF);
        chk("basic_count", o_count[1], 3'd2);
        chk("basic_head_ra", o_ra[1], 5'd1);
        chk("basic_head_wd", o_wd[1], 32'h5);
        t1 = o_ts[1];
        rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
        chk("basic_second_ra", o_ra[1], 5'd2);
        chk("basic_second_wd", o_wd[1], 32'hA);
        chk("basic_ts_incr", o_ts[1] > t1, 1'b1);
        rd_ready = 1'b1; cyc(); rd_ready = 1'b0;

        // Full behaviour: A overwrites oldest, B drops newest
        clr = 1'b1; cyc(); clr = 1'b0;
        cyc();
        for (int d = 1; d <= 6; d++) wr(5'd3, 32'(d));
        chk("wrap_count", o_count[0], 3'd4);
        chk("wrap_head", o_wd[0], 32'd3);
        chk("wrap_ovf", o_ovf[0], 1'b1);
        chk("wrap_drop", o_drop[0], 16'd2);
        chk("drop_head", o_wd[1], 32'd1);
        chk("drop_drop", o_drop[1], 16'd2);
        wb_valid = 1'b1; wb_ra = 5'd3; wb_wd = 32'd7; rd_ready = 1'b1;
        cyc();
        wb_valid = 1'b0; rd_ready = 1'b0;
        chk("drop_pp_count", o_count[1], 3'd4);
        chk("drop_pp_drop", o_drop[1], 16'd2);
        for (int k = 0; k < 4; k++) begin
            got[k] = o_wd[1];
            rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
        end
        chk("drop_after_pp_head", got[0], 32'd2);
        chk("drop_old_tail", got[2], 32'd4);

        // Async reset in the middle of traffic
        wr(5'd4, 32'h11);
        wb_valid = 1'b1; wb_ra = 5'd5; wb_wd = 32'h22;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("rst_count", o_count[0], 3'd0);
        chk("rst_valid", o_valid[1], 1'b0);
        wb_valid = 1'b0;
        cyc();
        rst_n = 1'b1; cap_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr(5'd6, 32'(k));
            cyc();
        end
        chk("idle_count", o_count[1], 3'd0);

        // Drop-count saturation
        cap_en = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) wr(5'd7, 32'(k + 100));
        force u_b.drop_q = 16'hFFFD;
        #1 release u_b.drop_q;
        m_drop[1] = 16'hFFFD;
        for (int k = 0; k < 3; k++) wr(5'd7, 32'(k + 200));
        chk("drop_saturate", o_drop[1], 16'hFFFF);

        // Timestamp wrap on the 4-bit stamp
        clr = 1'b1; cyc(); clr = 1'b0;
        cyc();
        repeat (15) cyc();
        wr(5'd8, 32'h81);
        wr(5'd9, 32'h82);
        chk("ts_wrap_15", o_ts[0], 16'd15);
        rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
        chk("ts_wrap_0", o_ts[0], 16'd0);

        // Halt on a stalled fetch PC
        clr = 1'b1; cyc(); clr = 1'b0;
        cyc();
        pc_walk = 1'b0;
        cur_pc = 32'h40;
        for (int k = 1; k <= HC; k++) begin
            if (k == 2 || k == HC) begin
                wb_valid = 1'b1; wb_ra = 5'd10; wb_wd = 32'(k);
            end
            cyc();
            wb_valid = 1'b0;
            chk($sformatf("halt_edge_%0d", k), o_halt[0], k == HC);
        end
        chk("halt_push_kept", o_count[1], 3'd2);
        wr(5'd11, 32'h99);
        chk("halt_push_ignored", o_count[1], 3'd2);
        rd_ready = 1'b1;
        for (int k = 0; k < 10 && (o_valid[0] || o_valid[1]); k++) cyc();
        rd_ready = 1'b0;
        chk("halt_drained", o_valid[0] | o_valid[1], 1'b0);
        cap_en = 1'b0;
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("clr_halted", o_halt[0], 1'b0);
        wr(5'd12, 32'h77);
        chk("clr_to_idle", o_count[0], 3'd0);

        // Randomised traffic
        pc_walk = 1'b0;
        for (int n = 0; n < 400; n++) begin
            wb_valid = ($urandom_range(0, 3) != 0);
            wb_ra    = 5'($urandom_range(0, 31));
            wb_wd    = $urandom;
            wb_pc    = $urandom;
            rd_ready = ($urandom_range(0, 2) == 0);
            cap_en   = ($urandom_range(0, 19) != 0);
            clr      = ($urandom_range(0, 99) == 0);
            cur_pc   = 32'($urandom_range(0, 3));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
